// File: rtl/sp_types_pkg.sv
// Shared store-path types: DRAM beat geometry and the row store controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sp_types_pkg;

    localparam int DRAM_BEAT_W   = 32;
    localparam int BEATS_PER_ROW = 4;
    localparam int DRAM_ROW_W    = DRAM_BEAT_W * BEATS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } dram_store_state_t;

endpackage

// File: rtl/dram_store_ctrl_if.sv
// Signal bundle between the store FSM, the row store controller and the DRAM write port.
// Latency: n/a (wiring only).
// Backpressure: dram_ready from DRAM stalls the current beat; sStore is held until sStore_hit.
interface dram_store_ctrl_if #(
    parameter int WORD_W       = 32,
    parameter int BEAT_W       = 32,
    parameter int BITS_PER_ROW = 128
);
    logic                    sStore;
    logic [WORD_W-1:0]       store_addr;
    logic [BITS_PER_ROW-1:0] store_data;
    logic                    sStore_hit;
    logic                    dram_wen;
    logic [WORD_W-1:0]       dram_addr;
    logic [BEAT_W-1:0]       dram_wdata;
    logic                    dram_ready;
    logic                    busy;
    logic                    store_err;

    modport ctrl (
        input  sStore, store_addr, store_data, dram_ready,
        output sStore_hit, dram_wen, dram_addr, dram_wdata, busy, store_err
    );
endinterface

// File: rtl/dram_store_ctrl.sv
// Row store controller: latches one row and writes it to DRAM as BITS_PER_ROW/BEAT_W beats.
// Latency: sStore_hit in cycle N+BEATS+1 for request cycle N, plus one cycle per ready-low cycle.
// Backpressure: beat held stable while dram_ready is low; optional stall abort (DRAM_STORE_TIMEOUT_EN).
//
// Ports: CLK/RST (async, active-high); sStore/store_addr/store_data request from the store FSM;
// sStore_hit/store_err completion pulse; dram_wen/dram_addr/dram_wdata/dram_ready beat handshake;
// busy high whenever not IDLE. Define DRAM_STORE_TIMEOUT_EN to enable the stall timeout.
module dram_store_ctrl
    import sp_types_pkg::*;
#(
    parameter int BEAT_W         = DRAM_BEAT_W,
    parameter int BITS_PER_ROW   = DRAM_ROW_W,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    sStore,
    input  logic [WORD_W-1:0]       store_addr,
    input  logic [BITS_PER_ROW-1:0] store_data,
    output logic                    sStore_hit,
    output logic                    dram_wen,
    output logic [WORD_W-1:0]       dram_addr,
    output logic [BEAT_W-1:0]       dram_wdata,
    input  logic                    dram_ready,
    output logic                    busy,
    output logic                    store_err
);

    localparam int BEATS   = BITS_PER_ROW / BEAT_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_AW  = $clog2(BITS_PER_ROW / 8);
    // Clears the byte-offset-within-row bits so the base is row aligned.
    localparam logic [WORD_W-1:0]  ADDR_MASK  = ~((WORD_W'(1) << ROW_AW) - WORD_W'(1));
    localparam logic [WORD_W-1:0]  BEAT_BYTES = WORD_W'(BEAT_W / 8);
    localparam logic [BEAT_CW-1:0] LAST_BEAT  = BEAT_CW'(BEATS - 1);

    dram_store_ctrl_if #(
        .WORD_W      (WORD_W),
        .BEAT_W      (BEAT_W),
        .BITS_PER_ROW(BITS_PER_ROW)
    ) u_if ();

    assign u_if.sStore     = sStore;
    assign u_if.store_addr = store_addr;
    assign u_if.store_data = store_data;
    assign u_if.dram_ready = dram_ready;

    dram_store_state_t       state_q, state_d;
    logic [BEAT_CW-1:0]      beat_q, beat_d;
    logic [WORD_W-1:0]       base_q, base_d;
    logic [BITS_PER_ROW-1:0] row_q, row_d;
    logic                    wen_w;
    logic                    hit_w;
    logic                    err_w;

`ifdef DRAM_STORE_TIMEOUT_EN
    localparam int TMO_CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TIMEOUT_CYCLES - 1);

    logic [TMO_CW-1:0] stall_q, stall_d;
    logic              err_q, err_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err_w = (state_q == DONE) && err_q;
`else
    // Constant 0; comparing against the stall limit keeps the parameter list shared by both builds.
    assign err_w = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        row_d   = row_q;
        wen_w   = 1'b0;
        hit_w   = 1'b0;
`ifdef DRAM_STORE_TIMEOUT_EN
        stall_d = stall_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (u_if.sStore) begin
                    base_d  = u_if.store_addr & ADDR_MASK;
                    row_d   = u_if.store_data;
                    beat_d  = '0;
                    state_d = WRITE;
`ifdef DRAM_STORE_TIMEOUT_EN
                    stall_d = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            WRITE: begin
                wen_w = 1'b1;
                if (u_if.dram_ready) begin
                    beat_d = beat_q + BEAT_CW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
`ifdef DRAM_STORE_TIMEOUT_EN
                    stall_d = '0;
                end else begin
                    // This stall cycle brings the consecutive count to the limit.
                    stall_d = stall_q + TMO_CW'(1);
                    if (stall_q == TMO_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                hit_w   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and data are pure functions of latched state, so they stay put while stalled.
    assign u_if.dram_wen   = wen_w;
    assign u_if.dram_addr  = wen_w ? (base_q + WORD_W'(beat_q) * BEAT_BYTES) : '0;
    assign u_if.dram_wdata = wen_w ? row_q[int'(beat_q) * BEAT_W +: BEAT_W] : '0;
    assign u_if.sStore_hit = hit_w;
    assign u_if.busy       = (state_q != IDLE);
    assign u_if.store_err  = err_w;

    assign sStore_hit = u_if.sStore_hit;
    assign dram_wen   = u_if.dram_wen;
    assign dram_addr  = u_if.dram_addr;
    assign dram_wdata = u_if.dram_wdata;
    assign busy       = u_if.busy;
    assign store_err  = u_if.store_err;

endmodule

// File: tb/tb_dram_store_ctrl.sv
// Directed bench for dram_store_ctrl (128-bit rows, 32-bit beats, 32-bit addresses).
// Latency: checks hit at N+BEATS+1 plus stall cycles.
// Backpressure: exercises ready-low stalls, async reset mid-row and back-to-back requests.
module tb_dram_store_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         sStore;
    logic [31:0]  store_addr;
    logic [127:0] store_data;
    logic         sStore_hit;
    logic         dram_wen;
    logic [31:0]  dram_addr;
    logic [31:0]  dram_wdata;
    logic         dram_ready;
    logic         busy;
    logic         store_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] ROW_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] ROW_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] ROW_C = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;

    always #5 CLK = ~CLK;

    dram_store_ctrl #(
        .BEAT_W        (32),
        .BITS_PER_ROW  (128),
        .WORD_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .sStore    (sStore),
        .store_addr(store_addr),
        .store_data(store_data),
        .sStore_hit(sStore_hit),
        .dram_wen  (dram_wen),
        .dram_addr (dram_addr),
        .dram_wdata(dram_wdata),
        .dram_ready(dram_ready),
        .busy      (busy),
        .store_err (store_err)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request from an IDLE cycle and walks all four beats, optionally stalling
    // stall_n cycles on beat stall_beat. With chain set, sStore stays high after the hit
    // and the next request's inputs are presented for the following IDLE cycle.
    task automatic run_row(input string tag, input logic [31:0] addr, input logic [127:0] data,
                           input logic [31:0] exp_base, input int stall_beat, input int stall_n,
                           input bit chain, input logic [31:0] next_addr,
                           input logic [127:0] next_data);
        logic [31:0] exp_w;
        sStore     = 1'b1;
        store_addr = addr;
        store_data = data;
        dram_ready = 1'b1;
        tick();
        // Inputs after the latch must not leak into the beats.
        store_addr = 32'hDEADBEEF;
        store_data = ~data;
        for (int b = 0; b < 4; b++) begin
            exp_w = data[b*32 +: 32];
            if (b == stall_beat) begin
                dram_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk({tag, "_stall_wen"},  dram_wen,   1'b1);
                    chk({tag, "_stall_addr"}, dram_addr,  exp_base + 32'(b * 4));
                    chk({tag, "_stall_data"}, dram_wdata, exp_w);
                    chk({tag, "_stall_hit"},  sStore_hit, 1'b0);
                    chk({tag, "_stall_err"},  store_err,  1'b0);
                    tick();
                end
                dram_ready = 1'b1;
            end
            chk({tag, "_wen"},  dram_wen,   1'b1);
            chk({tag, "_addr"}, dram_addr,  exp_base + 32'(b * 4));
            chk({tag, "_data"}, dram_wdata, exp_w);
            chk({tag, "_hit0"}, sStore_hit, 1'b0);
            chk({tag, "_busy"}, busy,       1'b1);
            tick();
        end
        chk({tag, "_hit"},      sStore_hit, 1'b1);
        chk({tag, "_err"},      store_err,  1'b0);
        chk({tag, "_done_wen"}, dram_wen,   1'b0);
        chk({tag, "_done_bsy"}, busy,       1'b1);
        if (chain) begin
            store_addr = next_addr;
            store_data = next_data;
        end else begin
            sStore = 1'b0;
        end
        tick();
        chk({tag, "_idle_hit"}, sStore_hit, 1'b0);
        chk({tag, "_idle_bsy"}, busy,       1'b0);
        chk({tag, "_idle_wen"}, dram_wen,   1'b0);
    endtask

    initial begin
        RST        = 1'b1;
        sStore     = 1'b0;
        store_addr = '0;
        store_data = '0;
        dram_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_wen",  dram_wen,   1'b0);
        chk("rst_hit",  sStore_hit, 1'b0);
        chk("rst_busy", busy,       1'b0);
        chk("rst_addr", dram_addr,  32'h0);
        chk("rst_data", dram_wdata, 32'h0);
        chk("rst_err",  store_err,  1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);

        // Plain row, ready always high: hit in N+5
        run_row("basic", 32'h0000_1000, ROW_A, 32'h0000_1000, 99, 0, 1'b0, '0, '0);

        // Three ready-low cycles on beat 2: hit in N+8, beat held at 0x1008
        run_row("stall", 32'h0000_1000, ROW_A, 32'h0000_1000, 2, 3, 1'b0, '0, '0);

        // Unaligned base at the top of the address space
        run_row("wrap", 32'hFFFF_FFF7, ROW_C, 32'hFFFF_FFF0, 99, 0, 1'b0, '0, '0);

        // Reset while beat 1 is on the bus
        sStore     = 1'b1;
        store_addr = 32'h0000_3000;
        store_data = ROW_B;
        dram_ready = 1'b1;
        tick();
        chk("rstmid_b0", dram_addr, 32'h0000_3000);
        tick();
        chk("rstmid_b1", dram_addr, 32'h0000_3004);
        #2;
        RST = 1'b1;
        #1;
        chk("rstmid_wen",  dram_wen,   1'b0);
        chk("rstmid_busy", busy,       1'b0);
        chk("rstmid_addr", dram_addr,  32'h0);
        chk("rstmid_data", dram_wdata, 32'h0);
        sStore = 1'b0;
        @(posedge CLK);
        #1;
        chk("rstmid_hit_a", sStore_hit, 1'b0);
        #2;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_hit_b", sStore_hit, 1'b0);
            chk("rstmid_idle",  busy,       1'b0);
        end
        run_row("restart", 32'h0000_3000, ROW_B, 32'h0000_3000, 99, 0, 1'b0, '0, '0);

        // Back-to-back: sStore held through DONE, second row taken in the next IDLE cycle
        run_row("b2b_a", 32'h0000_1000, ROW_A, 32'h0000_1000, 99, 0, 1'b1, 32'h0000_2000, ROW_B);
        run_row("b2b_b", 32'h0000_2000, ROW_B, 32'h0000_2000, 99, 0, 1'b0, '0, '0);

`ifdef DRAM_STORE_TIMEOUT_EN
        // Ready never rises: abort after 8 stall cycles with err and hit together
        sStore     = 1'b1;
        store_addr = 32'h0000_4000;
        store_data = ROW_C;
        dram_ready = 1'b0;
        tick();
        for (int s = 0; s < 8; s++) begin
            chk("tmo_wen", dram_wen,   1'b1);
            chk("tmo_hit", sStore_hit, 1'b0);
            chk("tmo_err", store_err,  1'b0);
            tick();
        end
        chk("tmo_hit_end", sStore_hit, 1'b1);
        chk("tmo_err_end", store_err,  1'b1);
        chk("tmo_wen_end", dram_wen,   1'b0);
        sStore = 1'b0;
        tick();
        chk("tmo_hit_clr", sStore_hit, 1'b0);
        chk("tmo_err_clr", store_err,  1'b0);
        chk("tmo_idle",    busy,       1'b0);
`else
        // Without the timeout a long stall just waits, well past the 8-cycle limit
        run_row("longstall", 32'h0000_4000, ROW_C, 32'h0000_4000, 1, 20, 1'b0, '0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_store_ctrl.md
DRAM_STORE_CTRL -- requirements
Module: dram_store_ctrl

Interface
REQ-001 SHALL have parameter BEAT_W, default 32: DRAM write beat width in bits; must divide BITS_PER_ROW.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: stall limit, used only with DRAM_STORE_TIMEOUT_EN.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port sStore, input, 1: store request from the store FSM, held high until sStore_hit.
REQ-006 SHALL have port store_addr, input, WORD_W: byte address of the row.
REQ-007 SHALL have port store_data, input, BITS_PER_ROW: row payload.
REQ-008 SHALL have port sStore_hit, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port dram_wen, output, 1: beat valid toward DRAM.
REQ-010 SHALL have port dram_addr, output, WORD_W: beat byte address.
REQ-011 SHALL have port dram_wdata, output, BEAT_W: beat data.
REQ-012 SHALL have port dram_ready, input, 1: DRAM accepts the beat when dram_wen and dram_ready are both high.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port store_err, output, 1: abort flag, pulsed with sStore_hit.

Function
REQ-015 SHALL implement the states IDLE, WRITE and DONE, with BEATS = BITS_PER_ROW/BEAT_W.
REQ-016 In IDLE with sStore high, SHALL latch store_addr (low log2(BITS_PER_ROW/8) bits forced 0) and store_data, clear beat counter, next WRITE.
REQ-017 SHALL ignore store_addr and store_data changes after latch until the next IDLE acceptance.
REQ-018 In WRITE, SHALL drive dram_wen=1, dram_addr=base+beat*(BEAT_W/8) mod 2^WORD_W, and dram_wdata=latched bits [(beat+1)*BEAT_W-1 : beat*BEAT_W].
REQ-019 SHALL hold dram_addr and dram_wdata stable while dram_wen is high and dram_ready is low.
REQ-020 On beat acceptance, SHALL increment beat; on acceptance of beat BEATS-1, next DONE.
REQ-021 In DONE, SHALL assert sStore_hit for exactly one cycle, next IDLE.
REQ-022 sStore high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-023 Latency: with dram_ready constantly high, sStore_hit SHALL occur in cycle N+BEATS+1 for request cycle N; each ready-low cycle adds one.
REQ-024 dram_wen SHALL be 0 in IDLE and DONE.
REQ-025 sStore_hit SHALL be 0 outside DONE.

Reset
REQ-026 On RST, SHALL immediately enter IDLE, clear beat counter, latched row and timeout counter, and drive all outputs to 0.
REQ-027 Reset mid-WRITE SHALL drop the partial row with no retry and no sStore_hit.

Configuration
REQ-028 With DRAM_STORE_TIMEOUT_EN defined, SHALL count consecutive WRITE cycles with dram_ready low, clearing the count on any accepted beat.
REQ-029 With DRAM_STORE_TIMEOUT_EN defined, on count reaching TIMEOUT_CYCLES, SHALL abort remaining beats, enter DONE, and pulse store_err with sStore_hit.
REQ-030 Without DRAM_STORE_TIMEOUT_EN, SHALL have no counter, tie store_err to 0, and wait on dram_ready indefinitely; the port list is identical in both builds.

Structure
REQ-031 SHALL place DRAM_BEAT_W, BEATS_PER_ROW and enum dram_store_state_t (IDLE, WRITE, DONE) in sp_types_pkg.
REQ-032 SHALL use the interface dram_store_ctrl_if, with a modport ctrl for this block.
REQ-033 SHALL be a single module with no sub-module.

Verification (BITS_PER_ROW=128, BEAT_W=32, WORD_W=32)
REQ-034 sStore=1, addr 0x1000, data 0x44..33..22..11 per word, ready=1 -> beats at 0x1000/0x1004/0x1008/0x100C carry 0x11.., 0x22.., 0x33.., 0x44..; hit in cycle N+5.
REQ-035 ready low 3 cycles on beat 2 -> dram_addr held at 0x1008 with data stable; hit in cycle N+8.
REQ-036 addr 0xFFFFFFF7 -> base 0xFFFFFFF0; beat 3 at 0xFFFFFFFC; no wrap beyond.
REQ-037 RST during beat 1 -> dram_wen 0 in the same cycle; no hit; next request restarts at beat 0.
REQ-038 Back-to-back requests, sStore held after hit with new addr 0x2000 -> second row accepted in the IDLE cycle following DONE.
REQ-039 TIMEOUT_EN with TIMEOUT_CYCLES=8, ready held 0 -> store_err=1 and hit=1 together after 8 stall cycles.
